// File: rtl/phase_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : phase_pkg                                                    |
// | Description : Shared phase-format constants and helpers for the phase      |
// |               accumulators feeding the CORDIC rotator (Q3.(M-3) signed).   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package phase_pkg;

  // Phase / step word width and channel count.
  localparam int M  = 32;
  localparam int CH = 4;
  localparam int CW = $clog2(CH);
  // Internal sum width: two guard bits so acc + step never overflows.
  localparam int MW = M + 2;

  // pi scaled by 2^(M-3), and 2*pi at the wide sum width.
  localparam logic signed [M-1:0]  PI     = 32'sh6487ED51;
  localparam logic signed [MW-1:0] PI_W   = MW'(PI);
  localparam logic signed [MW-1:0] TWO_PI = PI_W + PI_W;

  // Saturate a step value to [-PI, PI].
  function automatic logic [M-1:0] clamp_step(input logic [M-1:0] v);
    logic signed [M-1:0] s;
    logic [M-1:0]        r;
    s = signed'(v);
    r = v;
    if (s > PI) begin
      r = PI;
    end else if (s < -PI) begin
      r = -PI;
    end
    return r;
  endfunction

  // A loaded phase must lie in [-PI, PI); anything else is replaced by zero.
  function automatic logic [M-1:0] phase_load(input logic [M-1:0] v);
    logic signed [M-1:0] s;
    logic [M-1:0]        r;
    s = signed'(v);
    r = '0;
    if ((s >= -PI) && (s < PI)) begin
      r = v;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_wrap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : phase_wrap                                                   |
// | Description : Combinational phase add with single-step wrap to [-PI, PI).  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module phase_wrap #(
  parameter int             M      = 32,
  parameter logic [M-1:0]   PI     = 32'h6487ED51,
  parameter logic [M+1:0]   TWO_PI = 34'h0C90FDAA2
) (
  input  logic [M-1:0] acc_i,
  input  logic [M-1:0] step_i,
  output logic [M-1:0] nxt_o,
  output logic         wrap_o
);

  localparam int                    SW       = M + 2;
  localparam logic signed [SW-1:0]  PI_W     = signed'({2'b00, PI});
  localparam logic signed [SW-1:0]  NEG_PI_W = -PI_W;
  // The corrected result is truncated to M bits, so the correction itself can
  // be done modulo 2^M.
  localparam logic [M-1:0]          TWO_PI_M = TWO_PI[M-1:0];

  logic signed [SW-1:0] sum_w;

  assign sum_w = signed'({{2{acc_i[M-1]}}, acc_i}) + signed'({{2{step_i[M-1]}}, step_i});

  // One correction is enough because |step| <= PI and acc is in [-PI, PI).
  always_comb begin
    nxt_o  = sum_w[M-1:0];
    wrap_o = 1'b0;
    if (sum_w >= PI_W) begin
      nxt_o  = sum_w[M-1:0] - TWO_PI_M;
      wrap_o = 1'b1;
    end else if (sum_w < NEG_PI_W) begin
      nxt_o  = sum_w[M-1:0] + TWO_PI_M;
      wrap_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/phase_acc_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : phase_acc_mc                                                 |
// | Description : Time-interleaved multi-channel phase accumulator with a      |
// |               registered valid/ready output toward the CORDIC stage.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module phase_acc_mc
  import phase_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          cfg_we_i,
  input  logic          cfg_sel_i,
  input  logic [CW-1:0] cfg_ch_i,
  input  logic [M-1:0]  cfg_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [CW-1:0] out_ch_o,
  output logic [M-1:0]  phase_o,
  output logic          wrap_o
);

  logic [M-1:0]  step_q [CH];
  logic [M-1:0]  step_d [CH];
  logic [M-1:0]  acc_q  [CH];
  logic [M-1:0]  acc_d  [CH];
  logic [CW-1:0] ch_ptr_q;

  logic          out_valid_q;
  logic [CW-1:0] out_ch_q;
  logic [M-1:0]  phase_q;
  logic          wrap_q;

  logic          adv_w;
  logic [M-1:0]  nxt_w;
  logic          wrap_w;

  // Advance only when the output register is empty or being drained.
  assign adv_w = en_i & (~out_valid_q | out_ready_i);

  phase_wrap #(
    .M      (M),
    .PI     (PI),
    .TWO_PI (TWO_PI)
  ) u_wrap (
    .acc_i  (acc_q[ch_ptr_q]),
    .step_i (step_q[ch_ptr_q]),
    .nxt_o  (nxt_w),
    .wrap_o (wrap_w)
  );

  // Next state of the per-channel arrays; a phase load overrides the accumulate.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      step_d[i] = step_q[i];
      acc_d[i]  = acc_q[i];
    end
    if (adv_w) begin
      acc_d[ch_ptr_q] = nxt_w;
    end
    if (cfg_we_i) begin
      if (cfg_sel_i) begin
        acc_d[cfg_ch_i] = phase_load(cfg_data_i);
      end else begin
        step_d[cfg_ch_i] = clamp_step(cfg_data_i);
      end
    end
  end

  // Per-channel step and accumulator registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < CH; i++) begin
        step_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        step_q[i] <= step_d[i];
        acc_q[i]  <= acc_d[i];
      end
    end
  end

  // Round-robin pointer and output register with valid/ready handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ch_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      phase_q     <= '0;
      wrap_q      <= 1'b0;
    end else if (adv_w) begin
      ch_ptr_q    <= ch_ptr_q + CW'(1);
      out_valid_q <= 1'b1;
      out_ch_q    <= ch_ptr_q;
      phase_q     <= nxt_w;
      wrap_q      <= wrap_w;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_ch_o    = out_ch_q;
  assign phase_o     = phase_q;
  assign wrap_o      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_acc_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_phase_acc_mc                                              |
// | Description : Scoreboard bench for phase_acc_mc with a behavioural model.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_phase_acc_mc;

  localparam int     CH   = 4;
  localparam longint PI_L = 64'h6487ED51;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        cfg_we_i;
  logic        cfg_sel_i;
  logic [1:0]  cfg_ch_i;
  logic [31:0] cfg_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [1:0]  out_ch_o;
  logic [31:0] phase_o;
  logic        wrap_o;

  phase_acc_mc dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_sel_i   (cfg_sel_i),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_data_i  (cfg_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_ch_o    (out_ch_o),
    .phase_o     (phase_o),
    .wrap_o      (wrap_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [31:0] ph;
    bit          w;
  } exp_t;

  exp_t   exp_q[$];
  int     checks   = 0;
  int     failures = 0;

  // Behavioural model state: real-valued phases kept as plain integers.
  longint m_step [CH];
  longint m_acc  [CH];
  int     m_ptr     = 0;
  bit     m_valid   = 1'b0;
  bit     exp_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_step[i] = 0;
      m_acc[i]  = 0;
    end
    m_ptr     = 0;
    m_valid   = 1'b0;
    exp_valid = 1'b0;
    exp_q.delete();
  endtask

  // Drive one clock's worth of inputs and advance the model for that edge.
  task automatic cycle(input bit e, input bit r, input bit we, input bit sel,
                       input int ch, input logic [31:0] d);
    bit     adv;
    longint s;
    longint dv;
    bit     w;
    exp_t   item;
    @(posedge clk);
    #2;
    exp_valid   = m_valid;
    en_i        = e;
    out_ready_i = r;
    cfg_we_i    = we;
    cfg_sel_i   = sel;
    cfg_ch_i    = ch[1:0];
    cfg_data_i  = d;

    adv = e && (!m_valid || r);
    if (adv) begin
      s = m_acc[m_ptr] + m_step[m_ptr];
      w = 1'b0;
      if (s >= PI_L) begin
        s = s - 2 * PI_L;
        w = 1'b1;
      end else if (s < -PI_L) begin
        s = s + 2 * PI_L;
        w = 1'b1;
      end
      item.ch = m_ptr;
      item.ph = s[31:0];
      item.w  = w;
      exp_q.push_back(item);
      m_acc[m_ptr] = s;
      m_ptr        = (m_ptr + 1) % CH;
      m_valid      = 1'b1;
    end else if (r) begin
      m_valid = 1'b0;
    end

    // Configuration applies after the accumulate, so a phase load wins and a
    // step write only affects later updates.
    if (we) begin
      dv = longint'($signed(d));
      if (sel) begin
        m_acc[ch] = (dv >= -PI_L && dv < PI_L) ? dv : 0;
      end else begin
        m_step[ch] = (dv > PI_L) ? PI_L : ((dv < -PI_L) ? -PI_L : dv);
      end
    end
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0:       v = $urandom();
      1:       v = 32'h6487ED51 + $urandom_range(0, 40) - 20;
      2:       v = 32'h9B7812AF + $urandom_range(0, 40) - 20;
      3:       v = $urandom_range(0, 200000) - 100000;
      default: v = ($urandom_range(0, 1) == 1) ? 32'h7FFFFFFF : 32'h80000000;
    endcase
    return v;
  endfunction

  task automatic rand_cycle();
    cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 2, bit'($urandom_range(0, 1)),
          int'($urandom_range(0, CH - 1)), rand_data());
  endtask

  // Scoreboard monitor: checks valid each cycle and pops on every handshake.
  always @(negedge clk) begin
    exp_t e;
    chk("out_valid", 64'(out_valid_o), 64'(exp_valid));
    if (out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=output ch %0d required=no output", out_ch_o);
      end else begin
        e = exp_q.pop_front();
        chk("out_ch", 64'(out_ch_o), 64'(e.ch));
        chk("phase",  64'(phase_o),  64'(e.ph));
        chk("wrap",   64'(wrap_o),   64'(e.w));
      end
    end
  end

  initial begin
    rst_ni      = 1'b0;
    en_i        = 1'b0;
    out_ready_i = 1'b1;
    cfg_we_i    = 1'b0;
    cfg_sel_i   = 1'b0;
    cfg_ch_i    = '0;
    cfg_data_i  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst_ni = 1'b1;

    // Reset and idle.
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 0, 0, 0, 0);
      chk("idle_valid", 64'(out_valid_o), 64'd0);
      chk("idle_phase", 64'(phase_o), 64'd0);
      chk("idle_ch",    64'(out_ch_o), 64'd0);
    end

    // Round-robin accumulation with steps 1000..4000.
    for (int k = 0; k < CH; k++) cycle(0, 1, 1, 0, k, 32'(1000 * (k + 1)));
    repeat (12) cycle(1, 1, 0, 0, 0, 0);

    // Positive wrap on channel 0.
    cycle(0, 1, 1, 1, 0, 32'h6487ED51 - 32'd10);
    cycle(0, 1, 1, 0, 0, 32'd100);
    repeat (8) cycle(1, 1, 0, 0, 0, 0);

    // Step clamp then negative wrap on channel 1.
    cycle(0, 1, 1, 0, 1, 32'h7FFFFFFF);
    cycle(0, 1, 1, 1, 1, 32'd0);
    repeat (4) cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 1, 32'h9B7812AF);
    cycle(0, 1, 1, 0, 1, 32'hFFFFFFFB);
    repeat (8) cycle(1, 1, 0, 0, 0, 0);

    // Backpressure mid-stream.
    repeat (3) cycle(1, 1, 0, 0, 0, 0);
    repeat (5) cycle(1, 0, 0, 0, 0, 0);
    repeat (6) cycle(1, 1, 0, 0, 0, 0);

    // Phase load colliding with channel 2's own update.
    for (int k = 0; k < 8 && m_ptr != 2; k++) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 2, 32'd0);
    repeat (6) cycle(1, 1, 0, 0, 0, 0);

    // Randomized traffic.
    repeat (3000) rand_cycle();

    // Asynchronous reset while an output is stalled.
    repeat (3) cycle(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_ni   = 1'b0;
    en_i     = 1'b0;
    cfg_we_i = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", 64'(out_valid_o), 64'd0);
    chk("async_rst_phase", 64'(phase_o), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_ni = 1'b1;

    repeat (500) rand_cycle();
    repeat (10) cycle(0, 1, 0, 0, 0, 0);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
